apb_comp_responder: RTL and testbench

APB completer model that sits on each of the four completer ports of the crossbar NoC and answers transfers routed to it by the interconnect. It holds a small byte-strobed register memory and inserts a fixed number of wait states. It flags misaligned or illegal accesses with pslverr and keeps read and write counters. Each completer port of the bench instantiates one copy with its own COMP_ID.

---
 rtl/apb_comp_responder.sv | 208 ++++++++++++++++++++
 tb/tb_apb_comp_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_comp_responder.sv
// rtl/apb_comp_responder.sv - APB completer with ID word, byte-strobed register memory, fixed wait states and counters
//
// Parameters:
//   ADDR_W      paddr width (60)
//   DATA_W      data width, fixed at 32
//   MEM_DEPTH   number of 32-bit words, power of two 2..256
//   WAIT_CYCLES wait states per access phase, 0..15
//   COMP_ID     completer index 0..3, returned in word 0
// Ports:
//   pclk, preset_n                       clock, asynchronous active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb                        APB request from the crossbar
//   pready, prdata, pslverr              registered APB response
//   wr_cnt, rd_cnt                       error-free completed write/read counts

module apb_comp_responder #(
    parameter int ADDR_W      = 60,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int COMP_ID     = 0
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [3:0]        pstrb,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [DATA_W-1:0] ID_WORD = 32'hA9B0_0000 | 32'(COMP_ID);
    // The setup edge already accounts for one cycle of the wait budget, so the
    // counter starts one lower; WAIT_CYCLES=0 skips the WAIT state entirely.
    localparam logic [3:0] WCNT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wcnt;

    logic              req_write;
    logic [IW-1:0]     req_idx;
    logic              req_misalign;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_strb;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              setup;
    logic              access;
    logic              req_err;

    // Request view used to build the response: the live bus in IDLE (only
    // matters for the zero-wait path into DONE), otherwise the latched fields.
    logic              cur_write;
    logic [IW-1:0]     cur_idx;
    logic              cur_err;
    logic [DATA_W-1:0] cur_rdata;

    logic              pready_d;
    logic [DATA_W-1:0] prdata_d;
    logic              pslverr_d;
    logic              commit;

    // Address bits above the word index are decoded by the crossbar.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^paddr[ADDR_W-1:IW+2];

    assign setup   = psel & ~penable;
    assign access  = psel & penable;
    assign req_err = req_misalign | (req_write & (req_idx == '0));
    assign commit  = (state == S_DONE) && access;

    always_comb begin
        cur_write = req_write;
        cur_idx   = req_idx;
        cur_err   = req_err;
        if (state == S_IDLE) begin
            cur_write = pwrite;
            cur_idx   = paddr[IW+1:2];
            cur_err   = (paddr[1:0] != 2'b00) | (pwrite & (paddr[IW+1:2] == '0));
        end
        cur_rdata = (cur_idx == '0) ? ID_WORD : mem[cur_idx];
    end

    // State register
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (setup) begin
                    state_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_next = S_IDLE;
                end else if (wcnt == 4'd0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!psel || penable) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered response
    always_comb begin
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (state_next == S_DONE) begin
            if (state == S_DONE) begin
                pready_d  = pready;
                prdata_d  = prdata;
                pslverr_d = pslverr;
            end else begin
                pready_d  = 1'b1;
                pslverr_d = cur_err;
                prdata_d  = (cur_err || cur_write) ? '0 : cur_rdata;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            pready  <= pready_d;
            prdata  <= prdata_d;
            pslverr <= pslverr_d;
        end
    end

    // Request latch and wait counter
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wcnt         <= '0;
            req_write    <= 1'b0;
            req_idx      <= '0;
            req_misalign <= 1'b0;
            req_wdata    <= '0;
            req_strb     <= '0;
        end else begin
            if (state == S_IDLE && setup) begin
                wcnt         <= WCNT_LOAD;
                req_write    <= pwrite;
                req_idx      <= paddr[IW+1:2];
                req_misalign <= (paddr[1:0] != 2'b00);
                req_wdata    <= pwdata;
                req_strb     <= pstrb;
            end else if (state == S_WAIT && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    // Memory commit and counters at the completion edge
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit && !req_err) begin
            if (req_write) begin
                wr_cnt <= wr_cnt + 16'd1;
                for (int b = 0; b < 4; b++) begin
                    if (req_strb[b]) begin
                        mem[req_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                    end
                end
            end else begin
                rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_comp_responder.sv
// tb/tb_apb_comp_responder.sv - randomized self-checking bench for apb_comp_responder

module tb_apb_comp_responder;

    localparam int W     = 2;
    localparam int CID   = 2;
    localparam int DEPTH = 16;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [59:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [DEPTH];
    int          ref_wr;
    int          ref_rd;

    always #5 pclk = ~pclk;

    apb_comp_responder #(
        .ADDR_W(60), .DATA_W(32), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W), .COMP_ID(CID)
    ) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [59:0] mk_addr(input int idx, input int off);
        logic [59:0] a;
        a = 60'({$urandom, $urandom});
        a[5:0] = {4'(idx), 2'(off)};
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        ref_wr = 0;
        ref_rd = 0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(ref_wr));
        check({tag, "_rd_cnt"}, 64'(rd_cnt), 64'(ref_rd));
    endtask

    // One complete transfer; bus is left selected so a following call is back-to-back.
    task automatic xfer(input logic wr, input logic [59:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd);
        int          idx;
        logic        err;
        logic [31:0] exp_rd;
        int          waits;
        logic        seen;
        idx    = int'(addr[5:2]);
        err    = (addr[1:0] != 2'b00) || (wr && idx == 0);
        exp_rd = (err || wr) ? 32'h0
               : (idx == 0 ? (32'hA9B0_0000 | 32'(CID)) : ref_mem[idx]);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge pclk);
        // Scramble request fields during the access phase; they must be ignored.
        penable = 1'b1; pwrite = ~wr; paddr = 60'({$urandom, $urandom});
        pwdata = $urandom; pstrb = 4'($urandom);
        waits = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pready) begin
                seen = 1'b1;
                break;
            end
            waits++;
            @(negedge pclk);
        end
        check("pready_seen", 64'(seen), 64'd1);
        check("wait_states", 64'(waits), 64'(W));
        check("prdata", 64'(prdata), 64'(exp_rd));
        check("pslverr", 64'(pslverr), 64'(err));
        rd = prdata;
        @(posedge pclk);
        #1;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
                ref_wr = (ref_wr + 1) & 16'hFFFF;
            end else begin
                ref_rd = (ref_rd + 1) & 16'hFFFF;
            end
        end
        check("pready_one_cycle", 64'(pready), 64'd0);
        check_counters("xfer");
    endtask

    task automatic idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    // Start a transfer and drop psel after 'hold' access-phase cycles.
    task automatic abort_xfer(input logic wr, input logic [59:0] addr, input logic [31:0] data,
                              input int hold);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        repeat (hold) @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("abort_pready", 64'(pready), 64'd0);
        check("abort_pslverr", 64'(pslverr), 64'd0);
        check("abort_prdata", 64'(prdata), 64'd0);
        check_counters("abort");
    endtask

    initial begin
        logic [31:0] rd;
        preset_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        model_reset();
        repeat (3) @(negedge pclk);
        check("rst_pready", 64'(pready), 64'd0);
        check("rst_pslverr", 64'(pslverr), 64'd0);
        check("rst_prdata", 64'(prdata), 64'd0);
        check_counters("rst");
        preset_n = 1'b1;

        // ID register read
        xfer(1'b0, 60'h0, 32'h0, 4'h0, rd);
        check("id_word", 64'(rd), 64'hA9B0_0002);

        // Full write then readback of word 5
        xfer(1'b1, 60'h0000_0000_0000_014, 32'hDEAD_BEEF, 4'hF, rd);
        xfer(1'b0, 60'h0000_0000_0000_014, 32'h0, 4'h0, rd);
        check("full_readback", 64'(rd), 64'hDEAD_BEEF);

        // Byte-lane merge
        xfer(1'b1, mk_addr(5, 0), 32'h1122_3344, 4'b0101, rd);
        xfer(1'b0, mk_addr(5, 0), 32'h0, 4'h0, rd);
        check("merge_readback", 64'(rd), 64'hDE22_BE44);

        // Error transfers: misaligned write and write to ID word
        xfer(1'b1, 60'h2, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(1'b1, 60'h0, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(1'b0, mk_addr(0, 3), 32'h0, 4'h0, rd);
        xfer(1'b1, mk_addr(5, 1), 32'h0, 4'hF, rd);
        xfer(1'b0, mk_addr(5, 0), 32'h0, 4'h0, rd);
        check("err_no_change", 64'(rd), 64'hDE22_BE44);

        // Zero-strobe write counts but changes nothing
        xfer(1'b1, mk_addr(5, 0), 32'h0, 4'h0, rd);
        xfer(1'b0, mk_addr(5, 0), 32'h0, 4'h0, rd);
        check("zero_strb", 64'(rd), 64'hDE22_BE44);
        idle();

        // Three serialised requests, back-to-back
        begin
            int wr0, rd0;
            wr0 = ref_wr; rd0 = ref_rd;
            xfer(1'b1, mk_addr(7, 0), 32'hCAFE_0007, 4'hF, rd);
            xfer(1'b0, mk_addr(7, 0), 32'h0, 4'h0, rd);
            xfer(1'b1, mk_addr(9, 0), 32'hCAFE_0009, 4'hF, rd);
            check("three_sum", 64'(int'(wr_cnt) + int'(rd_cnt) - wr0 - rd0), 64'd3);
            idle();
        end

        // Aborts in WAIT and in DONE leave memory untouched
        abort_xfer(1'b1, mk_addr(7, 0), 32'h5555_5555, 1);
        abort_xfer(1'b1, mk_addr(7, 0), 32'h6666_6666, 2);
        xfer(1'b0, mk_addr(7, 0), 32'h0, 4'h0, rd);
        check("abort_no_commit", 64'(rd), 64'hCAFE_0007);
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            logic        wr;
            int          off;
            wr  = 1'($urandom);
            off = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            xfer(wr, mk_addr(int'($urandom_range(0, DEPTH - 1)), off), $urandom, 4'($urandom), rd);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        // Reset in the middle of a write
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = mk_addr(3, 0);
        pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset_n = 1'b0;
        #1;
        model_reset();
        check("midrst_pready", 64'(pready), 64'd0);
        check("midrst_pslverr", 64'(pslverr), 64'd0);
        check("midrst_prdata", 64'(prdata), 64'd0);
        check_counters("midrst");
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        preset_n = 1'b1;
        xfer(1'b0, mk_addr(3, 0), 32'h0, 4'h0, rd);
        check("midrst_mem3", 64'(rd), 64'h0);
        xfer(1'b0, mk_addr(7, 0), 32'h0, 4'h0, rd);
        check("midrst_mem7", 64'(rd), 64'h0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
